// File: rtl/clk_div_prog.sv
// Programmable integer clock divider: divides i_ref_clk by 1..2^W-1, ratio changes only at period boundaries.
// Optional macro CLK_DIV_PROG_DUTY50_EN adds a negedge flop giving exact 50% duty for odd ratios.
module clk_div_prog #(
    parameter int DIV_RATIO_WIDTH = 8
) (
    input  logic                       i_ref_clk,
    input  logic                       i_rst_n,
    input  logic                       i_clk_en,
    input  logic [DIV_RATIO_WIDTH-1:0] i_div_ratio,
    output logic                       o_div_clk,
    output logic                       o_tick,
    output logic [DIV_RATIO_WIDTH-1:0] o_ratio_cur
);

    localparam int W = DIV_RATIO_WIDTH;
    localparam logic [W-1:0] C_ZERO = '0;
    localparam logic [W-1:0] C_ONE  = W'(1);
    localparam logic [W-1:0] C_TWO  = W'(2);

    logic [W-1:0] r_cnt;
    logic [W-1:0] r_ratio_sh;
    logic         r_div_q;
    logic         r_tick;
    logic         r_run;

    logic         w_divide;
    logic         w_last;
    logic         w_load;
    logic [W-1:0] w_ratio_nxt;
    logic         w_divide_nxt;
    logic         w_keep;
    logic [W-1:0] w_cnt_nxt;
    logic [W-1:0] w_half;
    logic [W-1:0] w_thresh;
    logic         w_div_q_nxt;

    // ratio_sh >= 2 in DIVIDE, so ratio_sh-1 never underflows there.
    assign w_divide     = (r_ratio_sh >= C_TWO);
    assign w_last       = w_divide && (r_cnt == (r_ratio_sh - C_ONE));
    assign w_load       = !i_clk_en || !w_divide || w_last;
    assign w_ratio_nxt  = w_load ? i_div_ratio : r_ratio_sh;
    assign w_divide_nxt = (w_ratio_nxt >= C_TWO);

    // Keep dividing only if the following cycle is still in DIVIDE; otherwise park.
    assign w_keep    = i_clk_en && w_divide && w_divide_nxt;
    // r_run low means the period (re)starts: first active edge lands on cnt=0.
    assign w_cnt_nxt = (!r_run || w_last) ? C_ZERO : (r_cnt + C_ONE);
    assign w_half    = r_ratio_sh >> 1;

`ifdef CLK_DIV_PROG_DUTY50_EN
    assign w_thresh = w_half;
`else
    assign w_thresh = r_ratio_sh - w_half;
`endif

    assign w_div_q_nxt = (w_cnt_nxt < w_thresh);

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt      <= C_ZERO;
            r_ratio_sh <= C_ONE;
            r_div_q    <= 1'b0;
            r_tick     <= 1'b0;
            r_run      <= 1'b0;
        end else begin
            r_ratio_sh <= w_ratio_nxt;
            if (w_keep) begin
                r_cnt   <= w_cnt_nxt;
                r_div_q <= w_div_q_nxt;
                r_tick  <= (w_cnt_nxt == C_ZERO);
                r_run   <= 1'b1;
            end else begin
                r_cnt   <= C_ZERO;
                r_div_q <= 1'b0;
                r_tick  <= 1'b0;
                r_run   <= 1'b0;
            end
        end
    end

`ifdef CLK_DIV_PROG_DUTY50_EN
    logic r_neg_q;
    logic w_odd_ext;

    always_ff @(negedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_neg_q <= 1'b0;
        end else begin
            r_neg_q <= r_div_q;
        end
    end

    // Half-cycle extension only for odd ratios; even ratios are already 50%.
    assign w_odd_ext = r_ratio_sh[0] & r_neg_q;
`else
    logic w_odd_ext;
    assign w_odd_ext = 1'b0;
`endif

    // Bypass mux is gated by reset so the output is low throughout reset.
    assign o_div_clk   = w_divide ? (r_div_q | w_odd_ext)
                                  : (i_ref_clk & i_clk_en & i_rst_n);
    assign o_tick      = r_tick;
    assign o_ratio_cur = r_ratio_sh;

endmodule
